// File: rtl/lcd_bus_ctrl_if.sv
// LCD register/pin bundle between the LSU-side driver and lcd_bus_ctrl.
// The controller connects through the slave modport. The LSU/board side
// connects through the master modport.
interface lcd_bus_ctrl_if;
  logic [31:0] i_io_lcd;       // LCD register word from the LSU
  logic [7:0]  i_lcd_rdata;    // byte returned by the LCD pins on a read
  logic [7:0]  o_lcd_data;     // LCD data bus value
  logic        o_lcd_data_oe;  // 1 = drive the data bus
  logic        o_lcd_rs;       // register select
  logic        o_lcd_rw;       // 1 = read, 0 = write
  logic        o_lcd_en;       // enable strobe
  logic        o_lcd_on;       // power/backlight
  logic        o_lcd_busy;     // cycle or execution wait in progress
  logic [7:0]  o_lcd_rdata;    // last captured read byte

  modport slave (
    input  i_io_lcd, i_lcd_rdata,
    output o_lcd_data, o_lcd_data_oe, o_lcd_rs, o_lcd_rw, o_lcd_en,
           o_lcd_on, o_lcd_busy, o_lcd_rdata
  );

  modport master (
    output i_io_lcd, i_lcd_rdata,
    input  o_lcd_data, o_lcd_data_oe, o_lcd_rs, o_lcd_rw, o_lcd_en,
           o_lcd_on, o_lcd_busy, o_lcd_rdata
  );
endinterface

// File: rtl/lcd_bus_ctrl.sv
// HD44780-style character LCD bus sequencer.
// A rising edge on the EN request bit of the LSU's LCD register launches one
// bus cycle: address setup, enable pulse, hold, then the command-execution
// wait for writes. Clear and home commands get the long wait. One further
// request can be parked while a cycle runs. If several arrive, the last one
// is kept. All pins are registered.
module lcd_bus_ctrl #(
  parameter int T_SETUP     = 3,
  parameter int T_PULSE     = 25,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
  parameter int CNT_W       = 17
) (
  input logic           i_clk,
  input logic           i_reset,
  lcd_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
  } state_t;

  // Fields of one LCD bus cycle as captured from the register word.
  typedef struct packed {
    logic       rw;
    logic       rs;
    logic [7:0] data;
  } req_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [CNT_W-1:0] state_last;
  logic             last_cycle;
  logic             is_long;
  logic             done;

  logic             en_prev;
  logic             req;
  req_t             req_fields;
  req_t             cur, cur_n;
  req_t             pend, pend_n;
  logic             pending, pending_n;

  logic [7:0]       data_n;
  logic             oe_n, rs_n, rw_n, en_n, busy_n;

  // Bits [30:11] of the register word carry nothing for this block.
  logic             unused_io_bits;
  assign unused_io_bits = ^bus.i_io_lcd[30:11];

  // A request is the rising edge of the EN bit. A held level never retriggers.
  assign req        = bus.i_io_lcd[8] & ~en_prev;
  assign req_fields = {bus.i_io_lcd[10], bus.i_io_lcd[9], bus.i_io_lcd[7:0]};

  // Clear (0x01) and home (0x02/0x03) are the slow instructions.
  assign is_long    = ~cur.rs & ~cur.rw & (cur.data[7:2] == 6'd0);

  // Terminal timer count of the current state.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    state_last = '0;
    case (state)
      S_SETUP: state_last = CNT_W'(T_SETUP - 1);
      S_PULSE: state_last = CNT_W'(T_PULSE - 1);
      S_HOLD:  state_last = CNT_W'(T_HOLD - 1);
      S_EXEC:  state_last = is_long ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);
      default: state_last = '0;
    endcase
  end

  assign last_cycle = (timer == state_last);

  // State register with the timer, request history and request slots.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      en_prev <= 1'b0;
      cur     <= '0;
      pend    <= '0;
      pending <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state   <= state_n;
      timer   <= timer_n;
      en_prev <= bus.i_io_lcd[8];
      cur     <= cur_n;
      pend    <= pend_n;
      pending <= pending_n;
    end
  end

  // Next-state logic: phase sequencing, request parking and the done path.
  always_comb begin
    state_n   = state;
    timer_n   = timer + CNT_W'(1);
    cur_n     = cur;
    pend_n    = pend;
    pending_n = pending;
    done      = 1'b0;

    case (state)
      S_IDLE: begin
        timer_n = '0;
        if (req) begin
          state_n = S_SETUP;
          cur_n   = req_fields;
        end
      end
      S_SETUP: begin
        if (last_cycle) begin
          state_n = S_PULSE;
          timer_n = '0;
        end
      end
      S_PULSE: begin
        if (last_cycle) begin
          state_n = S_HOLD;
          timer_n = '0;
        end
      end
      S_HOLD: begin
        if (last_cycle) begin
          timer_n = '0;
          // Reads have no execution wait.
          if (cur.rw) done    = 1'b1;
          else        state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        if (last_cycle) done = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase

    // A request that arrives mid-cycle is parked. A newer one overwrites it.
    if (state != S_IDLE && req) begin
      pend_n    = req_fields;
      pending_n = 1'b1;
    end

    // Done path: launch the newest waiting request back-to-back, or go idle.
    // A request edge in this very cycle counts as the newest.
    if (done) begin
      timer_n = '0;
      if (req) begin
        state_n   = S_SETUP;
        cur_n     = req_fields;
        pending_n = 1'b0;
      end else if (pending) begin
        state_n   = S_SETUP;
        cur_n     = pend;
        pending_n = 1'b0;
      end else begin
        state_n   = S_IDLE;
      end
    end
  end

  // Output decode from the next state. The pins change together with the state.
  always_comb begin
    busy_n = (state_n != S_IDLE);
    en_n   = (state_n == S_PULSE);
    oe_n   = ((state_n == S_SETUP) || (state_n == S_PULSE) || (state_n == S_HOLD))
             & ~cur_n.rw;
    rs_n   = bus.o_lcd_rs;
    rw_n   = bus.o_lcd_rw;
    data_n = bus.o_lcd_data;
    // While idle the address/data pins keep their last values.
    if (busy_n) begin
      rs_n   = cur_n.rs;
      rw_n   = cur_n.rw;
      data_n = cur_n.data;
    end
  end

  // Pin registers, power follower and read-data capture.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bus.o_lcd_data    <= '0;
      bus.o_lcd_data_oe <= 1'b0;
      bus.o_lcd_rs      <= 1'b0;
      bus.o_lcd_rw      <= 1'b0;
      bus.o_lcd_en      <= 1'b0;
      bus.o_lcd_on      <= 1'b0;
      bus.o_lcd_busy    <= 1'b0;
      bus.o_lcd_rdata   <= '0;
    end else begin
      bus.o_lcd_data    <= data_n;
      bus.o_lcd_data_oe <= oe_n;
      bus.o_lcd_rs      <= rs_n;
      bus.o_lcd_rw      <= rw_n;
      bus.o_lcd_en      <= en_n;
      bus.o_lcd_on      <= bus.i_io_lcd[31];
      bus.o_lcd_busy    <= busy_n;
      // Sample the LCD's read data at the end of the enable pulse.
      if (state == S_PULSE && last_cycle && cur.rw) begin
        bus.o_lcd_rdata <= bus.i_lcd_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Directed bench for lcd_bus_ctrl using short timing parameters.
// Cycle 0 is the cycle in which the EN request edge is presented. Cycle c is
// sampled on the falling clock edge c periods later.
module tb_lcd_bus_ctrl;

  localparam int T_SETUP     = 2;
  localparam int T_PULSE     = 4;
  localparam int T_HOLD      = 1;
  localparam int T_EXEC      = 10;
  localparam int T_EXEC_LONG = 40;
  localparam int MAXC        = 128;

  logic clk;
  logic rst;
  lcd_bus_ctrl_if bus ();

  lcd_bus_ctrl #(
    .T_SETUP    (T_SETUP),
    .T_PULSE    (T_PULSE),
    .T_HOLD     (T_HOLD),
    .T_EXEC     (T_EXEC),
    .T_EXEC_LONG(T_EXEC_LONG),
    .CNT_W      (17)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-cycle trace of one transaction window.
  logic       en_h    [0:MAXC-1];
  logic       busy_h  [0:MAXC-1];
  logic       oe_h    [0:MAXC-1];
  logic       rs_h    [0:MAXC-1];
  logic [7:0] data_h  [0:MAXC-1];
  logic [7:0] rdata_h [0:MAXC-1];

  // Summary of the trace.
  int         n_busy, first_busy, last_busy;
  int         n_en, first_en, last_en, n_pulses, n_oe;
  logic [7:0] pulse_data [0:3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rec_clear();
    for (int i = 0; i < MAXC; i++) begin
      en_h[i] = 1'b0; busy_h[i] = 1'b0; oe_h[i] = 1'b0;
      rs_h[i] = 1'b0; data_h[i] = '0; rdata_h[i] = '0;
    end
  endtask

  // Advance to the falling edge of cycle c and record the pins.
  task automatic sample_one(input int c);
    @(posedge clk);
    @(negedge clk);
    en_h[c]    = bus.o_lcd_en;
    busy_h[c]  = bus.o_lcd_busy;
    oe_h[c]    = bus.o_lcd_data_oe;
    rs_h[c]    = bus.o_lcd_rs;
    data_h[c]  = bus.o_lcd_data;
    rdata_h[c] = bus.o_lcd_rdata;
  endtask

  task automatic record(input int n);
    rec_clear();
    for (int c = 1; c <= n; c++) sample_one(c);
  endtask

  task automatic summarize(input int n);
    n_busy = 0; first_busy = -1; last_busy = -1;
    n_en = 0; first_en = -1; last_en = -1; n_pulses = 0; n_oe = 0;
    for (int k = 0; k < 4; k++) pulse_data[k] = '0;
    for (int c = 1; c <= n; c++) begin
      if (busy_h[c]) begin
        n_busy++;
        if (first_busy < 0) first_busy = c;
        last_busy = c;
      end
      if (en_h[c]) begin
        n_en++;
        if (first_en < 0) first_en = c;
        last_en = c;
        if (!en_h[c-1]) begin
          if (n_pulses < 4) pulse_data[n_pulses] = data_h[c];
          n_pulses++;
        end
      end
      if (oe_h[c]) n_oe++;
    end
  endtask

  // Present a request edge: EN low for one cycle, then EN high (cycle 0).
  task automatic request(input logic [31:0] word);
    bus.i_io_lcd = word & ~32'h100;
    @(negedge clk);
    bus.i_io_lcd = word | 32'h100;
  endtask

  task automatic idle_cycles(input int n);
    bus.i_io_lcd = 32'h0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    bus.i_io_lcd    = 32'h0;
    bus.i_lcd_rdata = 8'h00;
    #1;
    check("reset_outputs",
          {bus.o_lcd_en, bus.o_lcd_busy, bus.o_lcd_data_oe, bus.o_lcd_rs,
           bus.o_lcd_rw, bus.o_lcd_on, bus.o_lcd_data, bus.o_lcd_rdata}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);

    // 1. Plain write of 0x38 (function set).
    bus.i_io_lcd = 32'h0000_0038;
    @(negedge clk);
    bus.i_io_lcd = 32'h0000_0138;
    record(20);
    summarize(20);
    check("wr_rs_c1",     rs_h[1], 1'b0);
    check("wr_data_c1",   data_h[1], 8'h38);
    check("wr_oe_c1",     oe_h[1], 1'b1);
    check("wr_en_c2",     en_h[2], 1'b0);
    check("wr_first_en",  first_en, 3);
    check("wr_last_en",   last_en, 6);
    check("wr_n_en",      n_en, 4);
    check("wr_oe_exec",   oe_h[10], 1'b0);
    check("wr_first_bsy", first_busy, 1);
    check("wr_n_busy",    n_busy, 17);
    check("wr_last_bsy",  last_busy, 17);
    check("wr_idle_c18",  busy_h[18], 1'b0);
    // EN stays high: no retrigger.
    record(50);
    summarize(50);
    check("held_n_busy",  n_busy, 0);
    check("held_n_en",    n_en, 0);
    idle_cycles(2);

    // 2. Clear (long wait), then 0x04 (normal wait).
    request(32'h0000_0001);
    record(60);
    summarize(60);
    check("clr_n_busy",   n_busy, 47);
    check("clr_contig",   last_busy - first_busy + 1, 47);
    check("clr_data",     pulse_data[0], 8'h01);
    idle_cycles(2);
    request(32'h0000_0004);
    record(30);
    summarize(30);
    check("ems_n_busy",   n_busy, 17);
    idle_cycles(2);

    // 3. Read: no data drive, byte captured at the end of the pulse, no EXEC.
    bus.i_lcd_rdata = 8'hA5;
    request(32'h0000_0400);
    record(15);
    summarize(15);
    check("rd_n_oe",      n_oe, 0);
    check("rd_rdata_c6",  rdata_h[6], 8'h00);
    check("rd_rdata_c7",  rdata_h[7], 8'hA5);
    check("rd_n_busy",    n_busy, 7);
    check("rd_n_en",      n_en, 4);
    idle_cycles(2);

    // 4. Queue: 0x41 runs, 0x42 and 0x43 arrive during its EXEC, 0x43 wins.
    request(32'h0000_0241);
    rec_clear();
    for (int c = 1; c <= 40; c++) begin
      sample_one(c);
      if (c == 8)  bus.i_io_lcd = 32'h0000_0242;
      if (c == 9)  bus.i_io_lcd = 32'h0000_0342;
      if (c == 10) bus.i_io_lcd = 32'h0000_0243;
      if (c == 11) bus.i_io_lcd = 32'h0000_0343;
    end
    summarize(40);
    check("q_n_pulses",   n_pulses, 2);
    check("q_pulse0",     pulse_data[0], 8'h41);
    check("q_pulse1",     pulse_data[1], 8'h43);
    check("q_rs_pulse",   rs_h[20], 1'b1);
    check("q_n_busy",     n_busy, 34);
    check("q_contig",     last_busy - first_busy + 1, 34);
    idle_cycles(2);

    // 5. Asynchronous reset while the enable pulse is high.
    request(32'h0000_0255);
    record(4);
    check("rst_en_before", en_h[4], 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_pins",
          {bus.o_lcd_en, bus.o_lcd_busy, bus.o_lcd_data_oe, bus.o_lcd_rs,
           bus.o_lcd_rw, bus.o_lcd_data, bus.o_lcd_rdata}, 32'h0);
    bus.i_io_lcd = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);
    request(32'h0000_0030);
    record(20);
    summarize(20);
    check("post_rst_first_en", first_en, 3);
    check("post_rst_data",     pulse_data[0], 8'h30);
    check("post_rst_n_busy",   n_busy, 17);
    idle_cycles(2);

    // 6. Power bit follows with one cycle of delay and never starts a cycle.
    rec_clear();
    bus.i_io_lcd = 32'h8000_0000;
    check("on_c0",        bus.o_lcd_on, 1'b0);
    sample_one(1);
    check("on_c1",        bus.o_lcd_on, 1'b1);
    bus.i_io_lcd = 32'h0;
    check("on_hold",      bus.o_lcd_on, 1'b1);
    sample_one(2);
    check("on_c2",        bus.o_lcd_on, 1'b0);
    summarize(2);
    check("on_busy",      n_busy, 0);
    check("on_en",        n_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
